// File: rtl/video_upscale_reader_pkg.sv
// Shared types and helpers for the display read path: scale factor, FSM state,
// stored pixel formats and the colour-bar lookup used by the optional test pattern.
package video_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_BLANK
  } state_e;

  localparam int unsigned PIX_FMT_RGB444 = 0;
  localparam int unsigned PIX_FMT_RGB565 = 1;

  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Reserved encoding 3 falls back to 1x.
  function automatic scale_e decode_scale(input logic [1:0] s);
    case (s)
      2'd1:    return SCALE_2X;
      2'd2:    return SCALE_4X;
      default: return SCALE_1X;
    endcase
  endfunction

  // Last sub-pixel/sub-line index for a scale factor (f-1).
  function automatic logic [1:0] sub_max(input scale_e f);
    case (f)
      SCALE_2X: return 2'd1;
      SCALE_4X: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    return {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  endfunction

endpackage

// File: rtl/video_upscale_reader_if.sv
// BRAM read port bundle: the read engine is the master, the image BRAM the slave.
interface video_upscale_reader_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned PIX_W  = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/video_upscale_reader_pixel_expand.sv
// Combinational stored-pixel to RGB888 expansion with MSB replication.
// Shared with the camera preview path.
module pixel_expand
  import video_pkg::*;
#(
  parameter int unsigned PIX_FMT = PIX_FMT_RGB444,
  parameter int unsigned PIX_W   = 12
) (
  input  logic [PIX_W-1:0] pix_i,
  output logic [23:0]      rgb_o
);

  if (PIX_FMT == PIX_FMT_RGB565) begin : g_rgb565
    assign rgb_o = {pix_i[15:11], pix_i[15:13],
                    pix_i[10:5],  pix_i[10:9],
                    pix_i[4:0],   pix_i[4:2]};
  end else begin : g_rgb444
    assign rgb_o = {pix_i[11:8], pix_i[11:8],
                    pix_i[7:4],  pix_i[7:4],
                    pix_i[3:0],  pix_i[3:0]};
  end

endmodule

// File: rtl/video_upscale_reader.sv
// Frame-buffer read engine with nearest-neighbour 1x/2x/4x upscaling and sync re-alignment.
// Define VUR_TEST_PATTERN_EN to replace BRAM data with 8 vertical colour bars.
module video_upscale_reader
  import video_pkg::*;
#(
  parameter int unsigned SRC_H   = 512,
  parameter int unsigned SRC_V   = 384,
  parameter int unsigned PIX_FMT = 0,
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                          i_clk_pixel,
  input  logic                          i_rstn,
  input  logic                          i_vde,
  input  logic                          i_hsync,
  input  logic                          i_vsync,
  input  logic [11:0]                   i_set_x,
  input  logic [11:0]                   i_set_y,
  input  logic [1:0]                    i_scale,
  video_upscale_reader_if.master        bram,
  output logic [23:0]                   o_video_data,
  output logic                          o_video_vde,
  output logic                          o_video_hsync,
  output logic                          o_video_vsync,
  output logic                          o_frame_start
);

  localparam int unsigned XW  = $clog2(SRC_H + 1);
  localparam int unsigned YW  = $clog2(SRC_V + 1);
  localparam int unsigned DLY = 2 + RD_LAT;

  localparam logic [XW-1:0]     XEnd     = XW'(SRC_H);
  localparam logic [YW-1:0]     YLast    = YW'(SRC_V - 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(SRC_H);

  state_e              state_q, state_d;
  scale_e              scale_q, scale_d;
  logic [XW-1:0]       src_x_q, src_x_d;
  logic [YW-1:0]       src_y_q, src_y_d;
  logic [1:0]          h_sub_q, h_sub_d;
  logic [1:0]          v_sub_q, v_sub_d;
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic                vsync_prev_q, vde_prev_q;
  logic                act_q, act_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                frame_start_q, frame_start_d;
  logic [RD_LAT-1:0]   act_pipe_q, act_pipe_d;
  logic [DLY-1:0][2:0] sync_q, sync_d;
  logic [23:0]         data_q, data_d;
  logic                vsync_rise, vde_fall;

  // Coordinates are implied by the incremental counters; kept on the port for the timing bus.
  logic unused_coords;
  assign unused_coords = ^{i_set_x, i_set_y};

  assign vsync_rise = i_vsync & ~vsync_prev_q;
  assign vde_fall   = vde_prev_q & ~i_vde;

  always_comb begin
    state_d       = state_q;
    scale_d       = scale_q;
    src_x_d       = src_x_q;
    src_y_d       = src_y_q;
    h_sub_d       = h_sub_q;
    v_sub_d       = v_sub_q;
    line_base_d   = line_base_q;
    act_d         = 1'b0;
    addr_d        = addr_q;
    frame_start_d = vsync_rise;

    // vsync wins over any in-progress line.
    if (vsync_rise) begin
      state_d     = S_FRAME;
      scale_d     = decode_scale(i_scale);
      src_x_d     = '0;
      src_y_d     = '0;
      h_sub_d     = '0;
      v_sub_d     = '0;
      line_base_d = '0;
    end else if (state_q == S_FRAME) begin
      if (i_vde && (src_x_q < XEnd)) begin
        act_d  = 1'b1;
        addr_d = line_base_q + ADDR_W'(src_x_q);
        if (h_sub_q == sub_max(scale_q)) begin
          h_sub_d = '0;
          src_x_d = src_x_q + 1'b1;
        end else begin
          h_sub_d = h_sub_q + 1'b1;
        end
      end
      if (vde_fall) begin
        src_x_d = '0;
        h_sub_d = '0;
        if (v_sub_q == sub_max(scale_q)) begin
          v_sub_d = '0;
          src_y_d = src_y_q + 1'b1;
          // line_base stops at the last source line rather than stepping past the image.
          if (src_y_q == YLast) begin
            state_d = S_BLANK;
          end else begin
            line_base_d = line_base_q + LineStep;
          end
        end else begin
          v_sub_d = v_sub_q + 1'b1;
        end
      end
    end
  end

  assign act_pipe_d = RD_LAT'({act_pipe_q, act_q});
  assign sync_d     = (3 * DLY)'({sync_q, {i_vde, i_hsync, i_vsync}});

`ifdef VUR_TEST_PATTERN_EN
  logic [2:0]             bar_q, bar_d;
  logic [RD_LAT-1:0][2:0] bar_pipe_q, bar_pipe_d;
  logic                   unused_rd_data;

  assign unused_rd_data = ^bram.rd_data;
  assign bar_d          = 3'((32'(src_x_q) * 32'd8) / SRC_H);
  assign bar_pipe_d     = (3 * RD_LAT)'({bar_pipe_q, bar_q});
  assign data_d         = act_pipe_q[RD_LAT-1] ? bar_colour(bar_pipe_q[RD_LAT-1]) : RGB_BLACK;
  assign bram.rd_en     = 1'b0;

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rstn) begin
      bar_q      <= '0;
      bar_pipe_q <= '0;
    end else begin
      bar_q      <= bar_d;
      bar_pipe_q <= bar_pipe_d;
    end
  end
`else
  logic [23:0] pix_rgb;

  pixel_expand #(
    .PIX_FMT (PIX_FMT),
    .PIX_W   (PIX_W)
  ) u_pixel_expand (
    .pix_i (bram.rd_data),
    .rgb_o (pix_rgb)
  );

  assign data_d     = act_pipe_q[RD_LAT-1] ? pix_rgb : RGB_BLACK;
  assign bram.rd_en = act_q;
`endif

  assign bram.rd_addr  = addr_q;
  assign o_video_data  = data_q;
  assign o_video_vde   = sync_q[DLY-1][2];
  assign o_video_hsync = sync_q[DLY-1][1];
  assign o_video_vsync = sync_q[DLY-1][0];
  assign o_frame_start = frame_start_q;

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rstn) begin
      state_q       <= S_IDLE;
      scale_q       <= SCALE_1X;
      src_x_q       <= '0;
      src_y_q       <= '0;
      h_sub_q       <= '0;
      v_sub_q       <= '0;
      line_base_q   <= '0;
      vsync_prev_q  <= 1'b0;
      vde_prev_q    <= 1'b0;
      act_q         <= 1'b0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      act_pipe_q    <= '0;
      sync_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      scale_q       <= scale_d;
      src_x_q       <= src_x_d;
      src_y_q       <= src_y_d;
      h_sub_q       <= h_sub_d;
      v_sub_q       <= v_sub_d;
      line_base_q   <= line_base_d;
      vsync_prev_q  <= i_vsync;
      vde_prev_q    <= i_vde;
      act_q         <= act_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
      act_pipe_q    <= act_pipe_d;
      sync_q        <= sync_d;
      data_q        <= data_d;
    end
  end

endmodule

// File: tb/tb_video_upscale_reader.sv
// Directed bench for video_upscale_reader on a 4x2 source image with a 1-cycle BRAM model.
module tb_video_upscale_reader;
  import video_pkg::*;

  localparam int unsigned SRC_H  = 4;
  localparam int unsigned SRC_V  = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PIX_W  = 12;

  logic        clk;
  logic        rstn, vde, hsync, vsync;
  logic [11:0] set_x, set_y;
  logic [1:0]  scale;
  logic [23:0] video_data;
  logic        video_vde, video_hsync, video_vsync, frame_start;
  logic [15:0] p565;
  logic [23:0] rgb565;
  logic [11:0] mem [8];

  int n_checks = 0;
  int n_fail   = 0;
  int fs_count = 0;
  logic [ADDR_W-1:0] rd_q[$];
  logic [23:0]       pix_q[$];
  int                exp_addr[$];
  logic [23:0]       exp_pix[$];
  logic [23:0]       first_pix;

  video_upscale_reader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bram_if ();

  video_upscale_reader #(
    .SRC_H   (SRC_H),
    .SRC_V   (SRC_V),
    .PIX_FMT (0),
    .PIX_W   (PIX_W),
    .ADDR_W  (ADDR_W),
    .RD_LAT  (1)
  ) dut (
    .i_clk_pixel   (clk),
    .i_rstn        (rstn),
    .i_vde         (vde),
    .i_hsync       (hsync),
    .i_vsync       (vsync),
    .i_set_x       (set_x),
    .i_set_y       (set_y),
    .i_scale       (scale),
    .bram          (bram_if),
    .o_video_data  (video_data),
    .o_video_vde   (video_vde),
    .o_video_hsync (video_hsync),
    .o_video_vsync (video_vsync),
    .o_frame_start (frame_start)
  );

  pixel_expand #(.PIX_FMT(PIX_FMT_RGB565), .PIX_W(16)) u_exp565 (.pix_i(p565), .rgb_o(rgb565));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bram_if.rd_en) bram_if.rd_data <= mem[bram_if.rd_addr];

  always @(negedge clk) begin
    if (bram_if.rd_en) rd_q.push_back(bram_if.rd_addr);
    if (video_vde) pix_q.push_back(video_data);
    if (frame_start) fs_count++;
  end

  function automatic logic [23:0] exp444(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  task automatic clear_caps();
    rd_q.delete();
    pix_q.delete();
    fs_count = 0;
  endtask

  // Nearest-neighbour model: output (x,y) maps to source (x/f, y/f); outside the image is black.
  task automatic build_exp(input int hact, input int vact, input int f);
    exp_addr.delete();
    exp_pix.delete();
    for (int l = 0; l < vact; l++) begin
      for (int x = 0; x < hact; x++) begin
        int sy = l / f;
        int sx = x / f;
        if (sy < int'(SRC_V) && sx < int'(SRC_H)) begin
          exp_addr.push_back(sy * int'(SRC_H) + sx);
          exp_pix.push_back(exp444(mem[sy * int'(SRC_H) + sx]));
        end else begin
          exp_pix.push_back(24'h000000);
        end
      end
    end
  endtask

  task automatic drive_vsync();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drive_line(input int hact);
    for (int x = 1; x <= hact; x++) begin
      @(negedge clk); vde = 1'b1; set_x = 12'(x);
    end
    @(negedge clk); vde = 1'b0; hsync = 1'b1;
    @(negedge clk);
    @(negedge clk); hsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int hact, input int vact, input logic [1:0] sc,
                           input logic [1:0] sc_mid);
    scale = sc;
    drive_vsync();
    for (int l = 0; l < vact; l++) begin
      set_y = 12'(l + 1);
      drive_line(hact);
      if (l == 0) scale = sc_mid;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; vde = 1'b0; hsync = 1'b0; vsync = 1'b0;
    set_x = '0; set_y = '0; scale = 2'd0; p565 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bram_if.rd_en !== 1'b0 || bram_if.rd_addr !== '0) begin
      n_fail++; $display("FAIL reset_bram: rd_en=%b rd_addr=%0d, required 0/0",
                         bram_if.rd_en, bram_if.rd_addr);
    end
    n_checks++;
    if (video_data !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 000000", video_data);
    end
    n_checks++;
    if ({video_vde, video_hsync, video_vsync, frame_start} !== 4'b0) begin
      n_fail++; $display("FAIL reset_syncs: got %b, required 0000",
                         {video_vde, video_hsync, video_vsync, frame_start});
    end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sync_delay();
    clear_caps();
    @(negedge clk); vde = 1'b1; hsync = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      logic e;
      @(negedge clk);
      e = (k >= 3);
      n_checks++;
      if (video_vde !== e || video_hsync !== e) begin
        n_fail++; $display("FAIL sync_delay_k%0d: vde=%b hsync=%b, required %b", k,
                           video_vde, video_hsync, e);
      end
    end
    vde = 1'b0; hsync = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++; $display("FAIL idle_no_read: %0d reads, required 0", rd_q.size());
    end
  endtask

  task automatic test_scale_1x();
    clear_caps();
    run_frame(4, 2, 2'd0, 2'd0);
    build_exp(4, 2, 1);
    n_checks++;
    if (rd_q.size() != exp_addr.size() || pix_q.size() != exp_pix.size()) begin
      n_fail++; $display("FAIL s1x_count: reads=%0d pix=%0d, required %0d/%0d",
                         rd_q.size(), pix_q.size(), exp_addr.size(), exp_pix.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (int'(rd_q[i]) != exp_addr[i]) begin
        n_fail++; $display("FAIL s1x_addr[%0d]: got %0d, required %0d", i, rd_q[i], exp_addr[i]);
      end
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix.size(); i++) begin
      n_checks++;
      if (pix_q[i] !== exp_pix[i]) begin
        n_fail++; $display("FAIL s1x_pix[%0d]: got %h, required %h", i, pix_q[i], exp_pix[i]);
      end
    end
    first_pix = (pix_q.size() > 0) ? pix_q[0] : 24'hxxxxxx;
    n_checks++;
    if (fs_count != 1) begin
      n_fail++; $display("FAIL s1x_frame_start: %0d pulses, required 1", fs_count);
    end
  endtask

  task automatic test_scale_2x(input int hact, input int vact, input string tag);
    clear_caps();
    run_frame(hact, vact, 2'd1, 2'd1);
    build_exp(hact, vact, 2);
    n_checks++;
    if (rd_q.size() != exp_addr.size() || pix_q.size() != exp_pix.size()) begin
      n_fail++; $display("FAIL %s_count: reads=%0d pix=%0d, required %0d/%0d", tag,
                         rd_q.size(), pix_q.size(), exp_addr.size(), exp_pix.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (int'(rd_q[i]) != exp_addr[i]) begin
        n_fail++; $display("FAIL %s_addr[%0d]: got %0d, required %0d", tag, i, rd_q[i],
                           exp_addr[i]);
      end
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix.size(); i++) begin
      n_checks++;
      if (pix_q[i] !== exp_pix[i]) begin
        n_fail++; $display("FAIL %s_pix[%0d]: got %h, required %h", tag, i, pix_q[i], exp_pix[i]);
      end
    end
  endtask

  task automatic test_scale_change();
    clear_caps();
    run_frame(4, 2, 2'd0, 2'd1);
    build_exp(4, 2, 1);
    n_checks++;
    if (rd_q.size() != exp_addr.size() || fs_count != 1) begin
      n_fail++; $display("FAIL chg_frameA: reads=%0d pulses=%0d, required %0d/1",
                         rd_q.size(), fs_count, exp_addr.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (int'(rd_q[i]) != exp_addr[i]) begin
        n_fail++; $display("FAIL chg_addrA[%0d]: got %0d, required %0d", i, rd_q[i], exp_addr[i]);
      end
    end
    clear_caps();
    run_frame(8, 4, 2'd1, 2'd1);
    build_exp(8, 4, 2);
    n_checks++;
    if (rd_q.size() != exp_addr.size() || fs_count != 1) begin
      n_fail++; $display("FAIL chg_frameB: reads=%0d pulses=%0d, required %0d/1",
                         rd_q.size(), fs_count, exp_addr.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (int'(rd_q[i]) != exp_addr[i]) begin
        n_fail++; $display("FAIL chg_addrB[%0d]: got %0d, required %0d", i, rd_q[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_pixel_expand();
    n_checks++;
    if (first_pix !== 24'h88AA33) begin
      n_fail++; $display("FAIL rgb444_8A3: got %h, required 88aa33", first_pix);
    end
    p565 = 16'hF81F; #1;
    n_checks++;
    if (rgb565 !== 24'hFF00FF) begin
      n_fail++; $display("FAIL rgb565_F81F: got %h, required ff00ff", rgb565);
    end
    p565 = 16'h07E0; #1;
    n_checks++;
    if (rgb565 !== 24'h00FF00) begin
      n_fail++; $display("FAIL rgb565_07E0: got %h, required 00ff00", rgb565);
    end
    p565 = 16'h8410; #1;
    n_checks++;
    if (rgb565 !== 24'h848284) begin
      n_fail++; $display("FAIL rgb565_8410: got %h, required 848284", rgb565);
    end
  endtask

  task automatic test_reset_midline();
    clear_caps();
    scale = 2'd0;
    drive_vsync();
    drive_line(4);
    for (int x = 1; x <= 4; x++) begin
      @(negedge clk);
      if (x == 4) begin
        n_checks++;
        if (bram_if.rd_en !== 1'b0 || video_data !== 24'h0 || video_vde !== 1'b0 ||
            frame_start !== 1'b0 || bram_if.rd_addr !== '0) begin
          n_fail++; $display("FAIL midreset_outputs: rd_en=%b addr=%0d data=%h vde=%b fs=%b, required all 0",
                             bram_if.rd_en, bram_if.rd_addr, video_data, video_vde, frame_start);
        end
        rd_q.delete();
        rstn = 1'b1;
      end
      vde = 1'b1; set_x = 12'(x);
      if (x == 3) rstn = 1'b0;
    end
    @(negedge clk); vde = 1'b0;
    repeat (3) @(negedge clk);
    drive_line(4);
    repeat (8) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_no_read: %0d reads, required 0", rd_q.size());
    end
    clear_caps();
    run_frame(4, 2, 2'd0, 2'd0);
    build_exp(4, 2, 1);
    n_checks++;
    if (rd_q.size() != exp_addr.size() || fs_count != 1) begin
      n_fail++; $display("FAIL midreset_resume: reads=%0d pulses=%0d, required %0d/1",
                         rd_q.size(), fs_count, exp_addr.size());
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (int'(rd_q[i]) != exp_addr[i]) begin
        n_fail++; $display("FAIL midreset_addr[%0d]: got %0d, required %0d", i, rd_q[i],
                           exp_addr[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 12'(32'h8A3 + 32'h105 * i);
    test_reset();
    test_sync_delay();
    test_scale_1x();
    test_scale_2x(8, 4, "s2x");
    test_scale_2x(12, 6, "ovf");
    test_scale_change();
    test_pixel_expand();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
